// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
// Watches a scanned seven-segment bus (one-hot digit select plus shared
// segment lines). Each digit is decoded back to BCD once its select and
// segment pattern have held steady for long enough. Decoded digits are
// collected into a multi-digit frame. A completed frame is handed
// downstream on a valid/ready interface.
module seg_scan_decoder #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DIGITS-1:0]     i_dig_sel,
  input  logic [6:0]            i_seg,
  input  logic                  i_out_ready,
  output logic                  o_out_valid,
  output logic [4*DIGITS-1:0]   o_bcd_out,
  output logic [DIGITS-1:0]     o_digit_err,
  output logic                  o_overrun
);

  localparam int SW = DIGITS + 7;
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_CAP = CW'(STABLE_CYCLES - 1);

  // Returns {err, bcd}. Unrecognised patterns decode to F with err set.
  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'b0111111: r = 5'h00;
      7'b0001010: r = 5'h01;
      7'b1110011: r = 5'h02;
      7'b1011011: r = 5'h03;
      7'b1001110: r = 5'h04;
      7'b1011101: r = 5'h05;
      7'b1111101: r = 5'h06;
      7'b0001011: r = 5'h07;
      7'b1111111: r = 5'h08;
      7'b1011111: r = 5'h09;
      default:    r = 5'h1F;
    endcase
    return r;
  endfunction

  logic [SW-1:0]       r_smp;
  logic [CW-1:0]       r_cnt;
  logic [4*DIGITS-1:0] r_slot_bcd;
  logic [DIGITS-1:0]   r_slot_err;
  logic [DIGITS-1:0]   r_seen;

  logic                w_same;
  logic [DIGITS-1:0]   w_sel;
  logic                w_onehot;
  logic                w_cap;
  logic [4:0]          w_dec;
  logic [DIGITS-1:0]   w_seen_nx;
  logic                w_complete;
  logic                w_load;
  logic [4*DIGITS-1:0] w_slot_bcd_nx;
  logic [DIGITS-1:0]   w_slot_err_nx;

  assign w_same     = ({i_dig_sel, i_seg} == r_smp);
  assign w_sel      = r_smp[SW-1:7];
  assign w_onehot   = (w_sel != '0) && ((w_sel & (w_sel - DIGITS'(1))) == '0);
  // The count saturates, so this equality is true only once per stable period.
  assign w_cap      = w_same && (r_cnt == CNT_CAP) && w_onehot;
  assign w_dec      = seg_decode(r_smp[6:0]);
  assign w_seen_nx  = r_seen | (w_cap ? w_sel : '0);
  assign w_complete = w_cap && (&w_seen_nx);
  assign w_load     = w_complete && (!o_out_valid || i_out_ready);

  // Slot contents after this edge's capture. Frame loading uses this view,
  // so the last digit of a frame is included with no added latency.
  always_comb begin
    w_slot_bcd_nx = r_slot_bcd;
    w_slot_err_nx = r_slot_err;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_cap && w_sel[i]) begin
        w_slot_bcd_nx[4*i +: 4] = w_dec[3:0];
        w_slot_err_nx[i]        = w_dec[4];
      end
    end
  end

  // Input sampler and saturating stability counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_smp <= '0;
      r_cnt <= '0;
    end else begin
      r_smp <= {i_dig_sel, i_seg};
      if (!w_same)
        r_cnt <= '0;
      else if (r_cnt != CNT_MAX)
        r_cnt <= r_cnt + CW'(1);
    end
  end

  // Per-digit slots and seen mask. The mask clears whenever a frame completes.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_slot_bcd <= '0;
      r_slot_err <= '0;
      r_seen     <= '0;
    end else begin
      r_slot_bcd <= w_slot_bcd_nx;
      r_slot_err <= w_slot_err_nx;
      r_seen     <= w_complete ? '0 : w_seen_nx;
    end
  end

  // Output frame register, handshake, and overrun pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_bcd_out   <= '0;
      o_digit_err <= '0;
      o_out_valid <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      o_overrun <= w_complete && !w_load;
      if (w_load) begin
        o_bcd_out   <= w_slot_bcd_nx;
        o_digit_err <= w_slot_err_nx;
        o_out_valid <= 1'b1;
      end else if (o_out_valid && i_out_ready) begin
        o_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Testbench for seg_scan_decoder. Directed scenarios are followed by a
// randomized scan sequence. Every cycle is compared with a reference model
// that counts how many consecutive edges each input value has been held.
module tb_seg_scan_decoder;

  localparam int DIGITS = 4;
  localparam int STABLE = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [DIGITS-1:0]   dig_sel = '0;
  logic [6:0]          seg = '0;
  logic                out_ready = 1'b0;
  logic                out_valid;
  logic [4*DIGITS-1:0] bcd_out;
  logic [DIGITS-1:0]   digit_err;
  logic                overrun;

  seg_scan_decoder #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
    .i_clk(clk), .i_rst(rst), .i_dig_sel(dig_sel), .i_seg(seg),
    .i_out_ready(out_ready), .o_out_valid(out_valid), .o_bcd_out(bcd_out),
    .o_digit_err(digit_err), .o_overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0] PAT [0:9];

  // Reference model state
  logic [DIGITS+6:0]   m_prev;
  int                  m_run;
  logic [3:0]          m_slot [DIGITS];
  logic                m_serr [DIGITS];
  logic                m_seen [DIGITS];
  logic                m_valid;
  logic                m_ovr;
  logic [4*DIGITS-1:0] m_bcd;
  logic [DIGITS-1:0]   m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_prev = '0; m_run = 0; m_valid = 0; m_ovr = 0; m_bcd = '0; m_err = '0;
    for (int i = 0; i < DIGITS; i++) begin
      m_slot[i] = 4'h0; m_serr[i] = 1'b0; m_seen[i] = 1'b0;
    end
  endtask

  // One clock edge of the reference model, using the inputs present at that edge.
  task automatic model_edge();
    logic [DIGITS+6:0] cur;
    logic [3:0] d;
    logic       e;
    int         idx;
    bit         all;
    cur = {dig_sel, seg};
    if (cur == m_prev) m_run++; else m_run = 1;
    m_prev = cur;
    m_ovr = 1'b0;
    if (m_run == STABLE + 1 && $countones(dig_sel) == 1) begin
      d = 4'hF; e = 1'b1;
      for (int k = 0; k < 10; k++)
        if (PAT[k] == seg) begin d = 4'(k); e = 1'b0; end
      idx = 0;
      for (int i = 0; i < DIGITS; i++) if (dig_sel[i]) idx = i;
      m_slot[idx] = d; m_serr[idx] = e; m_seen[idx] = 1'b1;
      all = 1;
      for (int i = 0; i < DIGITS; i++) if (!m_seen[i]) all = 0;
      if (all) begin
        for (int i = 0; i < DIGITS; i++) m_seen[i] = 1'b0;
        if (!m_valid || out_ready) begin
          for (int i = 0; i < DIGITS; i++) begin
            m_bcd[4*i +: 4] = m_slot[i];
            m_err[i]        = m_serr[i];
          end
          m_valid = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
        return;
      end
    end
    if (m_valid && out_ready) m_valid = 1'b0;
  endtask

  task automatic check_all();
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("bcd_out",   32'(bcd_out),   32'(m_bcd));
    chk("digit_err", 32'(digit_err), 32'(m_err));
    chk("overrun",   32'(overrun),   32'(m_ovr));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset(); else model_edge();
    #1;
    check_all();
  endtask

  task automatic hold(input logic [DIGITS-1:0] s, input logic [6:0] g, input int n);
    dig_sel = s; seg = g;
    repeat (n) tick();
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
  task automatic do_reset();
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_valid",   32'(out_valid), 32'h0);
    chk("rst_bcd",     32'(bcd_out),   32'h0);
    chk("rst_err",     32'(digit_err), 32'h0);
    chk("rst_overrun", 32'(overrun),   32'h0);
    tick(); tick();
    dig_sel = '0; seg = '0; out_ready = 1'b0;
    rst = 1'b0;
  endtask

  int ovr_cnt;

  initial begin
    PAT[0] = 7'b0111111; PAT[1] = 7'b0001010; PAT[2] = 7'b1110011;
    PAT[3] = 7'b1011011; PAT[4] = 7'b1001110; PAT[5] = 7'b1011101;
    PAT[6] = 7'b1111101; PAT[7] = 7'b0001011; PAT[8] = 7'b1111111;
    PAT[9] = 7'b1011111;
    model_reset();

    // Reset, then idle inputs
    do_reset();
    hold(4'b0000, 7'b0000000, 6);
    chk("idle_valid", 32'(out_valid), 32'h0);

    // Full frame 3,1,6,0 with out_ready low
    hold(4'b0001, 7'b1011011, 8);
    hold(4'b0010, 7'b0001010, 8);
    hold(4'b0100, 7'b1111101, 8);
    hold(4'b1000, 7'b0111111, 4);
    chk("frame_valid_e4", 32'(out_valid), 32'h0);
    tick();
    chk("frame_valid_e5", 32'(out_valid), 32'h1);
    tick(); tick(); tick();
    chk("frame_bcd", 32'(bcd_out),   32'h0613);
    chk("frame_err", 32'(digit_err), 32'h0);

    // Glitch: digit 0 held only 4 edges, so the frame cannot complete
    do_reset();
    hold(4'b0001, 7'b1011011, 4);
    hold(4'b0010, 7'b0001010, 6);
    hold(4'b0100, 7'b1111101, 6);
    hold(4'b1000, 7'b0111111, 6);
    chk("glitch_no_frame", 32'(out_valid), 32'h0);
    hold(4'b0001, 7'b1001110, 6);
    chk("glitch_late_frame", 32'(bcd_out), 32'h0614);

    // Bad pattern in digit 2
    do_reset();
    hold(4'b0001, PAT[9], 6);
    hold(4'b0010, PAT[8], 6);
    hold(4'b0100, 7'b1111110, 6);
    hold(4'b1000, PAT[7], 6);
    chk("bad_nibble2", 32'(bcd_out[11:8]), 32'hF);
    chk("bad_err",     32'(digit_err),     32'b0100);

    // Backpressure: a second frame completes while the first is unaccepted
    ovr_cnt = 0;
    for (int i = 0; i < DIGITS; i++) begin
      dig_sel = 4'(1 << i); seg = PAT[i + 2];
      repeat (6) begin tick(); if (overrun) ovr_cnt++; end
    end
    chk("bp_overrun_cnt", 32'(ovr_cnt),       32'h1);
    chk("bp_bcd_kept",    32'(bcd_out[3:0]),  32'h9);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("bp_accept_drop", 32'(out_valid), 32'h0);

    // Acceptance on the same edge as completion keeps out_valid high
    for (int i = 0; i < DIGITS; i++) hold(4'(1 << i), PAT[i], 6);
    chk("co_valid_pre", 32'(out_valid), 32'h1);
    for (int i = 0; i < DIGITS - 1; i++) hold(4'(1 << i), PAT[9 - i], 6);
    hold(4'b1000, PAT[5], 4);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("co_valid_post", 32'(out_valid), 32'h1);
    chk("co_bcd",        32'(bcd_out),   32'h5789);
    tick();

    // Illegal selects never capture
    do_reset();
    hold(4'b0011, PAT[1], 10);
    hold(4'b0000, PAT[2], 10);
    hold(4'b0100, PAT[3], 6);
    hold(4'b1000, PAT[4], 6);
    hold(4'b0001, PAT[5], 6);
    chk("illegal_no_valid", 32'(out_valid), 32'h0);

    // Randomized scan sequence
    for (int n = 0; n < 400; n++) begin
      logic [DIGITS-1:0] s;
      logic [6:0] g;
      if ($urandom_range(0, 9) < 8) s = 4'(1 << $urandom_range(0, DIGITS - 1));
      else s = 4'($urandom);
      if ($urandom_range(0, 9) < 9) g = PAT[$urandom_range(0, 9)];
      else g = 7'($urandom);
      out_ready = ($urandom_range(0, 3) == 0);
      hold(s, g, $urandom_range(1, 8));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
